cpu_run_ctrl: RTL
=================

Name: cpu_run_ctrl

Overview:
- Run/step/halt sequencer for the pipelined MIPS core; gates the core's clock enable and sits between the debug/host command port and the core top level.
- Supports free-run, single-instruction step (terminates on the core's instruction-retire pulse) and a hardware PC breakpoint on the core's PC output.
- Keeps retired-instruction and enabled-cycle counters for the debug view.

Parameters:
- PC_W, 9, width of core PC output and breakpoint address.
- CNT_W, 32, width of the retire and cycle counters.
- STEP_TMO, 64, maximum enabled cycles allowed for one step before abort.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command strobe.
- cmd_op  in  2  command: 0 NOP, 1 RUN, 2 STEP, 3 HALT.
- cmd_ready  out  1  command accepted this cycle when cmd_valid and cmd_ready are both high.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  PC_W  breakpoint PC.
- pco  in  PC_W  core PC output.
- inst_done  in  1  core retire pulse, one cycle per instruction.
- core_en  out  1  clock enable to the core.
- state  out  2  current state: 0 HALTED, 1 RUN, 2 STEP.
- bp_hit  out  1  sticky flag: halted by breakpoint.
- step_err  out  1  sticky flag: step timed out.
- clr_cnt  in  1  synchronous clear of both counters.
- retired  out  CNT_W  retired-instruction count.
- cycles  out  CNT_W  enabled-cycle count.

Behaviour:
- Reset, while rst is low, asynchronous:
  - state=HALTED, core_en=0, bp_hit=0, step_err=0.
  - retired=0, cycles=0, step timer=0, bp_skip=0.
- cmd_ready = (state != STEP). Commands arriving in STEP are held off, never dropped.
- bp_match = bp_en & (pco == bp_addr) & !bp_skip.
- core_en is combinational: (state==RUN & !bp_match) | (state==STEP).
- HALTED state:
  - RUN goes to RUN. STEP goes to STEP and loads the timer with 0.
  - Accepting RUN or STEP clears bp_hit and step_err.
  - HALT and NOP have no effect.
- RUN state:
  - bp_match goes to HALTED next edge and sets bp_hit. The matching cycle already has core_en=0, so the instruction at bp_addr does not advance.
  - HALT goes to HALTED. STEP is accepted and ignored. RUN is a no-op.
  - If bp_match and HALT occur in the same cycle: go to HALTED and set bp_hit.
- STEP state:
  - core_en=1 every cycle; the timer increments each cycle.
  - inst_done goes to HALTED next edge; core_en drops after that edge, exactly one retire per step.
  - If the timer reaches STEP_TMO-1 without inst_done: go to HALTED and set step_err.
  - If inst_done and timeout coincide, inst_done wins and step_err stays 0.
  - Breakpoints are not evaluated in STEP.
- bp_skip:
  - Set on entry to RUN or STEP when pco==bp_addr, so the core can resume from a breakpoint.
  - Cleared on any cycle where pco != bp_addr.
- Counters:
  - retired += 1 when inst_done & core_en. cycles += 1 when core_en.
  - Both wrap modulo 2^CNT_W.
  - clr_cnt wins over a simultaneous increment; the counter becomes 0.
- Reset asserted mid-step or mid-run: immediate return to reset values; the core is frozen via core_en=0.
- inst_done while core_en=0 is ignored and counts nothing.

Decomposition:
- Shared package cpu_dbg_pkg:
  - state encoding: ST_HALTED=0, ST_RUN=1, ST_STEP=2.
  - command opcodes: OP_NOP=0, OP_RUN=1, OP_STEP=2, OP_HALT=3.
  - default PC_W/CNT_W constants.
- Sub-module dbg_counter: CNT_W-wide enable/clear/wrap counter, instantiated twice for retired and cycles.
- FSM, breakpoint compare and step timer stay in cpu_run_ctrl.

Test Plan:
- Reset, then STEP with inst_done pulsed on the 5th enabled cycle -> core_en high 5 cycles, then low; state=HALTED; retired=1; cycles=5; step_err=0.
- bp_en=1, bp_addr=0x010, RUN, pco counts 0x00C, 0x00D, ... -> core_en=0 in the cycle pco=0x010; state=HALTED next edge; bp_hit=1. A second RUN then advances past 0x010 (bp_skip) and clears bp_hit.
- STEP with no inst_done, STEP_TMO=64 -> HALTED after 64 enabled cycles; step_err=1; retired=0; cycles=64. Next STEP clears step_err.
- HALT issued during STEP -> cmd_ready=0 until the step completes; HALT is accepted the cycle after returning to HALTED with no state change.
- Preload: run until cycles=2^CNT_W-1, enable one more cycle -> cycles=0. clr_cnt asserted together with an inst_done retire -> retired=0.
- Drop rst low mid-RUN at an arbitrary, non-edge time -> core_en=0, state=0 and all counters/flags 0 immediately. After rst rises, the block remains HALTED until a command arrives.

Source files
------------

// File: rtl/cpu_dbg_pkg.sv
// Shared encodings and default widths for the core run/step/halt debug controller.
package cpu_dbg_pkg;

   localparam int unsigned PC_W_DEF     = 9;
   localparam int unsigned CNT_W_DEF    = 32;
   localparam int unsigned STEP_TMO_DEF = 64;

   typedef enum logic [1:0] {
      ST_HALTED = 2'd0,
      ST_RUN    = 2'd1,
      ST_STEP   = 2'd2
   } run_state_e;

   typedef enum logic [1:0] {
      OP_NOP  = 2'd0,
      OP_RUN  = 2'd1,
      OP_STEP = 2'd2,
      OP_HALT = 2'd3
   } cmd_op_e;

endpackage

// File: rtl/dbg_counter.sv
// Free-running event counter with synchronous clear (clear beats increment) and natural wrap.
module dbg_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer for the pipelined core: gates core_en, handles a PC breakpoint
// with resume-skip, a bounded single step, and retired/enabled-cycle counters.
module cpu_run_ctrl
   import cpu_dbg_pkg::*;
#(
   parameter int unsigned PC_W     = PC_W_DEF,
   parameter int unsigned CNT_W    = CNT_W_DEF,
   parameter int unsigned STEP_TMO = STEP_TMO_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   input  logic [1:0]       cmd_op,
   output logic             cmd_ready,
   input  logic             bp_en,
   input  logic [PC_W-1:0]  bp_addr,
   input  logic [PC_W-1:0]  pco,
   input  logic             inst_done,
   output logic             core_en,
   output logic [1:0]       state,
   output logic             bp_hit,
   output logic             step_err,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] retired,
   output logic [CNT_W-1:0] cycles
);

   localparam int unsigned       TMR_W    = (STEP_TMO > 2) ? $clog2(STEP_TMO) : 1;
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(STEP_TMO - 1);

   run_state_e       state_q, state_d;
   logic             bp_hit_q, bp_hit_d;
   logic             step_err_q, step_err_d;
   logic             bp_skip_q, bp_skip_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             pc_at_bp, bp_match, cmd_acc;

   assign pc_at_bp  = (pco == bp_addr);
   assign bp_match  = bp_en & pc_at_bp & ~bp_skip_q;
   assign cmd_ready = (state_q != ST_STEP);
   assign cmd_acc   = cmd_valid & cmd_ready;
   // The matching cycle is already frozen so the instruction at bp_addr never advances.
   assign core_en   = ((state_q == ST_RUN) & ~bp_match) | (state_q == ST_STEP);
   assign state     = 2'(state_q);
   assign bp_hit    = bp_hit_q;
   assign step_err  = step_err_q;

   // Next-state, flags, step timer and breakpoint resume-skip.
   always_comb begin
      state_d    = state_q;
      bp_hit_d   = bp_hit_q;
      step_err_d = step_err_q;
      tmr_d      = tmr_q;
      bp_skip_d  = bp_skip_q & pc_at_bp;
      case (state_q)
         ST_HALTED: begin
            if (cmd_acc && (cmd_op == OP_RUN || cmd_op == OP_STEP)) begin
               bp_hit_d   = 1'b0;
               step_err_d = 1'b0;
               bp_skip_d  = pc_at_bp;
               tmr_d      = '0;
               state_d    = (cmd_op == OP_RUN) ? ST_RUN : ST_STEP;
            end
         end
         ST_RUN: begin
            if (bp_match) begin
               state_d  = ST_HALTED;
               bp_hit_d = 1'b1;
            end else if (cmd_acc && cmd_op == OP_HALT) begin
               state_d = ST_HALTED;
            end
         end
         ST_STEP: begin
            if (inst_done) begin
               state_d = ST_HALTED;
            end else if (tmr_q == TMR_LAST) begin
               state_d    = ST_HALTED;
               step_err_d = 1'b1;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         default: state_d = ST_HALTED;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_HALTED;
         bp_hit_q   <= 1'b0;
         step_err_q <= 1'b0;
         bp_skip_q  <= 1'b0;
         tmr_q      <= '0;
      end else begin
         state_q    <= state_d;
         bp_hit_q   <= bp_hit_d;
         step_err_q <= step_err_d;
         bp_skip_q  <= bp_skip_d;
         tmr_q      <= tmr_d;
      end
   end

   dbg_counter #(.W(CNT_W)) u_retired (
      .clk (clk),
      .rst (rst),
      .en  (inst_done & core_en),
      .clr (clr_cnt),
      .cnt (retired)
   );

   dbg_counter #(.W(CNT_W)) u_cycles (
      .clk (clk),
      .rst (rst),
      .en  (core_en),
      .clr (clr_cnt),
      .cnt (cycles)
   );

endmodule
